// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit slots with anti-ghost dead time,
// per-digit blink and a double-buffered frame load port that only swaps on frame boundaries.
module display_scan_ctrl #(
  parameter int                NUM_DIGITS   = 4,
  parameter int                CODE_W       = 4,
  parameter int                SCAN_DIV     = 50000,
  parameter int                DEAD_CYCLES  = 1,
  parameter int                BLINK_FRAMES = 64,
  parameter logic [CODE_W-1:0] BLANK_CODE   = 4'hF,
  parameter bit                DIG_ACT_LOW  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NUM_DIGITS*CODE_W-1:0] load_codes,
  input  logic [NUM_DIGITS-1:0]        load_blink,
  output logic [CODE_W-1:0]            code_out,
  output logic [NUM_DIGITS-1:0]        digit_en,
  output logic                         frame_tick
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = DIG_ACT_LOW ? '1 : '0;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [FRAME_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic                  pending_q, pending_d;
  logic [CODE_W-1:0]     shd_code_q [NUM_DIGITS];
  logic [CODE_W-1:0]     shd_code_d [NUM_DIGITS];
  logic [CODE_W-1:0]     act_code_q [NUM_DIGITS];
  logic [CODE_W-1:0]     act_code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shd_mask_q, shd_mask_d;
  logic [NUM_DIGITS-1:0] act_mask_q, act_mask_d;
  logic [CODE_W-1:0]     code_out_q, code_out_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  presc_wrap, slot_last, frame_wrap, accept;
  logic [NUM_DIGITS-1:0] en_onehot;

  assign load_ready = !pending_q;
  assign code_out   = code_out_q;
  assign digit_en   = digit_en_q;
  assign frame_tick = frame_tick_q;

  always_comb begin
    presc_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
    slot_last  = (slot_q == SLOT_W'(NUM_DIGITS - 1));
    frame_wrap = presc_wrap && slot_last;
    accept     = load_valid && !pending_q;

    presc_d     = presc_wrap ? '0 : presc_q + PRESC_W'(1);
    slot_d      = slot_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (presc_wrap) begin
      slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
    end
    if (frame_wrap) begin
      if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_ph_d  = !blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end

    // Accept and copy are mutually exclusive: accept needs pending clear, copy needs it set.
    pending_d  = pending_q;
    shd_code_d = shd_code_q;
    shd_mask_d = shd_mask_q;
    act_code_d = act_code_q;
    act_mask_d = act_mask_q;
    if (frame_wrap && pending_q) begin
      act_code_d = shd_code_q;
      act_mask_d = shd_mask_q;
      pending_d  = 1'b0;
    end else if (accept) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shd_code_d[k] = load_codes[k*CODE_W +: CODE_W];
      end
      shd_mask_d = load_blink;
      pending_d  = 1'b1;
    end

    // Outputs are a registered view of the current slot; code stays valid through dead time.
    en_onehot = '0;
    if (!(presc_q < PRESC_W'(DEAD_CYCLES)) && !(blink_ph_q && act_mask_q[slot_q])) begin
      en_onehot[slot_q] = 1'b1;
    end
    digit_en_d   = DIG_ACT_LOW ? ~en_onehot : en_onehot;
    code_out_d   = act_code_q[slot_q];
    frame_tick_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      slot_q       <= '0;
      frame_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      pending_q    <= 1'b0;
      shd_mask_q   <= '0;
      act_mask_q   <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shd_code_q[k] <= BLANK_CODE;
        act_code_q[k] <= BLANK_CODE;
      end
      code_out_q   <= BLANK_CODE;
      digit_en_q   <= EN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_ph_q   <= blink_ph_d;
      pending_q    <= pending_d;
      shd_code_q   <= shd_code_d;
      shd_mask_q   <= shd_mask_d;
      act_code_q   <= act_code_d;
      act_mask_q   <= act_mask_d;
      code_out_q   <= code_out_d;
      digit_en_q   <= digit_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 4-digit, 4-cycle-slot, 2-frame-blink configuration.
// Cycle k counts rising edges since reset release; outputs after edge k reflect state index k-1.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_codes;
  logic [3:0]  load_blink;
  logic [3:0]  code_out;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int k         = 0;

  display_scan_ctrl #(
    .NUM_DIGITS(4), .CODE_W(4), .SCAN_DIV(4), .DEAD_CYCLES(1),
    .BLINK_FRAMES(2), .BLANK_CODE(4'hF), .DIG_ACT_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_codes(load_codes), .load_blink(load_blink),
    .code_out(code_out), .digit_en(digit_en), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          lv;
    logic [15:0] codes;
    logic [3:0]  blink;
    logic [3:0]  en;
    logic [3:0]  code;
    bit          tick;
    bit          ready;
  } vec_t;

  vec_t vec [80];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
  endtask

  // One clock with the given inputs; expected display comes from the active frame content ec/em.
  task automatic cyc(input bit lv, input logic [15:0] c, input logic [3:0] b,
                     input logic [15:0] ec, input logic [3:0] em);
    int idx, p, s, ph;
    logic [3:0] exp_en;
    load_valid = lv;
    load_codes = c;
    load_blink = b;
    @(posedge clk);
    @(negedge clk);
    k++;
    idx = k - 1;
    p  = idx % 4;
    s  = (idx / 4) % 4;
    ph = (idx / 32) % 2;
    exp_en = (p == 0 || (ph == 1 && em[s])) ? 4'b0000 : 4'(1 << s);
    chk("digit_en", 32'(digit_en), 32'(exp_en));
    chk("code_out", 32'(code_out), 32'(ec[s*4 +: 4]));
    chk("frame_tick", 32'(frame_tick), 32'(k % 16 == 0));
  endtask

  initial begin
    logic [15:0] code_a, code_b, code_c, code_d;
    code_a = 16'h4567;
    code_b = 16'h89AB;
    code_c = 16'h1357;
    code_d = 16'h2468;

    // Frames 0..4: idle frame, load {3,2,1,0} with mask 0010 accepted at edge 6, blink frames 2-3.
    for (int i = 0; i < 80; i++) begin
      int kk, s, f;
      kk = i + 1;
      s  = (i / 4) % 4;
      f  = i / 16;
      vec[i].lv    = (kk == 6);
      vec[i].codes = 16'h3210;
      vec[i].blink = 4'b0010;
      vec[i].ready = !(kk >= 6 && kk <= 15);
      vec[i].code  = (f == 0) ? 4'hF : 4'(s);
      vec[i].en    = ((i % 4) == 0 || ((f / 2) % 2 == 1 && s == 1)) ? 4'b0000 : 4'(1 << s);
      vec[i].tick  = (kk % 16 == 0);
    end

    rst_n = 1'b0;
    load_valid = 1'b0;
    load_codes = '0;
    load_blink = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_code", 32'(code_out), 32'hF);
    chk("rst_en", 32'(digit_en), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);

    for (int i = 0; i < 80; i++) begin
      load_valid = vec[i].lv;
      load_codes = vec[i].codes;
      load_blink = vec[i].blink;
      @(posedge clk);
      @(negedge clk);
      k++;
      chk("tbl_en", 32'(digit_en), 32'(vec[i].en));
      chk("tbl_code", 32'(code_out), 32'(vec[i].code));
      chk("tbl_tick", 32'(frame_tick), 32'(vec[i].tick));
      chk("tbl_ready", 32'(load_ready), 32'(vec[i].ready));
    end

    // Held valid: A accepted at 83, B offered while pending, taken only the cycle after the copy.
    cyc(0, code_a, 4'b0000, 16'h3210, 4'b0010);
    cyc(0, code_a, 4'b0000, 16'h3210, 4'b0010);
    cyc(1, code_a, 4'b0000, 16'h3210, 4'b0010);
    chk("hold_ready_a", 32'(load_ready), 32'h0);
    for (int i = 84; i <= 96; i++) cyc(1, code_b, 4'b0000, 16'h3210, 4'b0010);
    chk("hold_ready_copy", 32'(load_ready), 32'h1);
    cyc(1, code_b, 4'b0000, code_a, 4'b0000);
    chk("hold_ready_b", 32'(load_ready), 32'h0);
    for (int i = 98; i <= 112; i++) cyc(0, code_b, 4'b0000, code_a, 4'b0000);

    // Accept on the boundary edge 128 with nothing pending: C shows only from frame 9.
    for (int i = 113; i <= 127; i++) cyc(0, code_c, 4'b0000, code_b, 4'b0000);
    chk("bnd_ready_pre", 32'(load_ready), 32'h1);
    cyc(1, code_c, 4'b0000, code_b, 4'b0000);
    chk("bnd_ready_acc", 32'(load_ready), 32'h0);
    for (int i = 129; i <= 144; i++) cyc(0, code_c, 4'b0000, code_b, 4'b0000);
    chk("bnd_ready_post", 32'(load_ready), 32'h1);

    // Reset mid-slot with D pending: outputs blank at once, D never shows afterwards.
    for (int i = 145; i <= 149; i++) cyc(0, code_d, 4'b1111, code_c, 4'b0000);
    cyc(1, code_d, 4'b1111, code_c, 4'b0000);
    chk("rst2_pend", 32'(load_ready), 32'h0);
    cyc(0, code_d, 4'b1111, code_c, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("rst2_code", 32'(code_out), 32'hF);
    chk("rst2_en", 32'(digit_en), 32'h0);
    chk("rst2_tick", 32'(frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    chk("rst2_ready", 32'(load_ready), 32'h1);
    for (int i = 0; i < 32; i++) begin
      cyc(0, code_d, 4'b1111, 16'hFFFF, 4'b0000);
      chk("rst2_idle_ready", 32'(load_ready), 32'h1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
